// File: rtl/tohost_monitor_pkg.sv
// rtl/tohost_monitor_pkg.sv - shared types and constants for the tohost monitor
package tohost_monitor_pkg;

   typedef enum logic [1:0] {
      EVT_NONE    = 2'd0,
      EVT_PASS    = 2'd1,
      EVT_FAIL    = 2'd2,
      EVT_TIMEOUT = 2'd3
   } evt_kind_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE_PASS,
      ST_DONE_FAIL,
      ST_DONE_TIMEOUT
   } core_state_t;

   typedef struct packed {
      logic [1:0]  core;
      evt_kind_t   kind;
      logic [31:0] code;
   } evt_t;

   localparam logic [63:0] PASS_VALUE = 64'd1;

endpackage

// File: rtl/tohost_evt_fifo.sv
// rtl/tohost_evt_fifo.sv - event queue with drop reporting when pushed while full
module tohost_evt_fifo
   import tohost_monitor_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_push,
   input  evt_t i_push_evt,
   input  logic i_pop_ready,
   output logic o_valid,
   output evt_t o_head,
   output logic o_drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   evt_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_full;
   logic w_pop;
   logic w_push_ok;

   assign o_valid   = (r_count != '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_pop     = o_valid & i_pop_ready;
   // A full queue can still take a push when the head leaves in the same cycle.
   assign w_push_ok = i_push & (~w_full | w_pop);
   assign o_drop    = i_push & ~w_push_ok;
   assign o_head    = o_valid ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_evt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tohost_monitor.sv
// rtl/tohost_monitor.sv - per-core tohost pass/fail/timeout monitor with event queue
module tohost_monitor
   import tohost_monitor_pkg::*;
#(
   parameter int          NUM_CORES      = 4,
   parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter int          FIFO_DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_valid,
   input  logic [1:0]           wr_core,
   input  logic [31:0]          wr_addr,
   input  logic [63:0]          wr_data,
   input  logic                 check_en,
   input  logic [NUM_CORES-1:0] core_active,
   output logic [NUM_CORES-1:0] pass_status,
   output logic [NUM_CORES-1:0] fail_status,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [1:0]           evt_core,
   output logic [1:0]           evt_kind,
   output logic [31:0]          evt_code,
   output logic                 overflow
);

   localparam int              WD_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);

   logic                 w_store_ok;
   logic                 w_is_pass;
   logic [NUM_CORES-1:0] w_hit;
   logic                 w_hit_any;
   logic [NUM_CORES-1:0] w_tpend;
   logic [NUM_CORES-1:0] w_tpop;
   logic                 w_tsel_valid;
   logic [1:0]           w_tsel_idx;
   logic                 w_push;
   evt_t                 w_push_evt;
   evt_t                 w_head;
   logic                 w_drop;
   logic                 r_overflow;

   // Even stores (including zero) never count as a hit, so bit 0 alone qualifies the data.
   assign w_store_ok = wr_valid & check_en & (wr_addr == TOHOST_ADDR) & wr_data[0];
   assign w_is_pass  = (wr_data == PASS_VALUE);
   assign w_hit_any  = |w_hit;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      core_state_t     r_state;
      logic [WD_W-1:0] r_wd;
      logic            r_pass;
      logic            r_fail;
      logic            r_tpend;

      assign w_hit[i] = w_store_ok & (int'(wr_core) == i) & (r_state == ST_RUN);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wd    <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_tpend <= 1'b0;
         end else begin
            if (w_tpop[i]) begin
               r_tpend <= 1'b0;
            end
            if (!core_active[i]) begin
               r_state <= ST_IDLE;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     r_state <= ST_RUN;
                     r_wd    <= '0;
                     r_pass  <= 1'b0;
                     r_fail  <= 1'b0;
                  end
                  ST_RUN: begin
                     // A store landing on the expiry cycle wins over the watchdog.
                     if (w_hit[i]) begin
                        if (w_is_pass) begin
                           r_pass  <= 1'b1;
                           r_state <= ST_DONE_PASS;
                        end else begin
                           r_fail  <= 1'b1;
                           r_state <= ST_DONE_FAIL;
                        end
                     end else if (WD_EN) begin
                        if (r_wd == WD_LAST) begin
                           r_fail  <= 1'b1;
                           r_tpend <= 1'b1;
                           r_state <= ST_DONE_TIMEOUT;
                        end else begin
                           r_wd <= r_wd + WD_W'(1);
                        end
                     end
                  end
                  default: r_state <= r_state;
               endcase
            end
         end
      end

      assign pass_status[i] = r_pass;
      assign fail_status[i] = r_fail;
      assign w_tpend[i]     = r_tpend;
   end

   always_comb begin
      w_tsel_valid = 1'b0;
      w_tsel_idx   = '0;
      w_tpop       = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (w_tpend[k] && !w_tsel_valid) begin
            w_tsel_valid = 1'b1;
            w_tsel_idx   = 2'(k);
            w_tpop[k]    = ~w_hit_any;
         end
      end
   end

   always_comb begin
      w_push          = w_hit_any | w_tsel_valid;
      w_push_evt      = '0;
      if (w_hit_any) begin
         w_push_evt.core = wr_core;
         w_push_evt.kind = w_is_pass ? EVT_PASS : EVT_FAIL;
         w_push_evt.code = w_is_pass ? 32'd0 : wr_data[32:1];
      end else begin
         w_push_evt.core = w_tsel_idx;
         w_push_evt.kind = EVT_TIMEOUT;
         w_push_evt.code = 32'd0;
      end
   end

   tohost_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_evt  (w_push_evt),
      .i_pop_ready (evt_ready),
      .o_valid     (evt_valid),
      .o_head      (w_head),
      .o_drop      (w_drop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;
   assign evt_core = w_head.core;
   assign evt_kind = w_head.kind;
   assign evt_code = w_head.code;

endmodule

// File: tb/tb_tohost_monitor.sv
// tb/tb_tohost_monitor.sv - directed self-checking bench for tohost_monitor
module tb_tohost_monitor;

   localparam logic [31:0] ADDR = 32'h8000_1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_valid = 1'b0;
   logic [1:0]  wr_core = 2'd0;
   logic [31:0] wr_addr = 32'd0;
   logic [63:0] wr_data = 64'd0;
   logic        check_en = 1'b0;
   logic [3:0]  core_active = 4'b0000;
   logic [3:0]  pass_status;
   logic [3:0]  fail_status;
   logic        evt_valid;
   logic        evt_ready = 1'b0;
   logic [1:0]  evt_core;
   logic [1:0]  evt_kind;
   logic [31:0] evt_code;
   logic        overflow;

   int n_vec = 0;
   int n_err = 0;

   tohost_monitor #(
      .NUM_CORES      (4),
      .TOHOST_ADDR    (ADDR),
      .TIMEOUT_CYCLES (16),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_valid    (wr_valid),
      .wr_core     (wr_core),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .check_en    (check_en),
      .core_active (core_active),
      .pass_status (pass_status),
      .fail_status (fail_status),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_core    (evt_core),
      .evt_kind    (evt_kind),
      .evt_code    (evt_code),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d, input logic en);
      wr_valid = 1'b1;
      wr_core  = c;
      wr_addr  = a;
      wr_data  = d;
      check_en = en;
      tick();
      wr_valid = 1'b0;
      check_en = 1'b0;
   endtask

   task automatic pop();
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({pass_status, fail_status, overflow} !== 9'b0) begin
         n_err++;
         $display("FAIL reset_status: got pass=%b fail=%b ovf=%b expected all 0", pass_status, fail_status, overflow);
      end
      n_vec++;
      if ({evt_valid, evt_core, evt_kind, evt_code} !== 37'h0) begin
         n_err++;
         $display("FAIL reset_evt: got v=%b core=%0d kind=%0d code=%h expected all 0", evt_valid, evt_core, evt_kind, evt_code);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_pass();
      core_active = 4'b0001;
      tick();
      store(2'd0, ADDR, 64'h1, 1'b1);
      n_vec++;
      if ({pass_status, fail_status} !== 8'b0001_0000) begin
         n_err++;
         $display("FAIL pass_status: got pass=%b fail=%b expected 0001/0000", pass_status, fail_status);
      end
      n_vec++;
      if ({evt_valid, evt_core, evt_kind, evt_code} !== {1'b1, 2'd0, 2'd1, 32'd0}) begin
         n_err++;
         $display("FAIL pass_evt: got v=%b core=%0d kind=%0d code=%h expected 1/0/1/0", evt_valid, evt_core, evt_kind, evt_code);
      end
      pop();
      n_vec++;
      if (evt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL pass_pop: got evt_valid=%b expected 0", evt_valid);
      end
      core_active = 4'b0000;
      tick();
   endtask

   task automatic test_fail();
      core_active = 4'b0100;
      tick();
      store(2'd2, ADDR, 64'h15, 1'b1);
      n_vec++;
      if ({pass_status, fail_status} !== 8'b0001_0100) begin
         n_err++;
         $display("FAIL fail_status: got pass=%b fail=%b expected 0001/0100", pass_status, fail_status);
      end
      n_vec++;
      if ({evt_valid, evt_core, evt_kind, evt_code} !== {1'b1, 2'd2, 2'd2, 32'hA}) begin
         n_err++;
         $display("FAIL fail_evt: got v=%b core=%0d kind=%0d code=%h expected 1/2/2/a", evt_valid, evt_core, evt_kind, evt_code);
      end
      store(2'd2, ADDR, 64'h1, 1'b1);
      n_vec++;
      if ({pass_status, fail_status} !== 8'b0001_0100) begin
         n_err++;
         $display("FAIL fail_then_pass: got pass=%b fail=%b expected 0001/0100", pass_status, fail_status);
      end
      n_vec++;
      if ({evt_valid, evt_core, evt_kind, evt_code} !== {1'b1, 2'd2, 2'd2, 32'hA}) begin
         n_err++;
         $display("FAIL fail_hold: got v=%b core=%0d kind=%0d code=%h expected 1/2/2/a", evt_valid, evt_core, evt_kind, evt_code);
      end
      pop();
      n_vec++;
      if (evt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fail_extra_evt: got evt_valid=%b expected 0", evt_valid);
      end
      core_active = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      core_active = 4'b0010;
      tick();
      repeat (15) tick();
      n_vec++;
      if (fail_status !== 4'b0100) begin
         n_err++;
         $display("FAIL timeout_early: got fail=%b expected 0100", fail_status);
      end
      tick();
      n_vec++;
      if ({pass_status, fail_status} !== 8'b0001_0110) begin
         n_err++;
         $display("FAIL timeout_status: got pass=%b fail=%b expected 0001/0110", pass_status, fail_status);
      end
      tick();
      n_vec++;
      if ({evt_valid, evt_core, evt_kind, evt_code} !== {1'b1, 2'd1, 2'd3, 32'd0}) begin
         n_err++;
         $display("FAIL timeout_evt: got v=%b core=%0d kind=%0d code=%h expected 1/1/3/0", evt_valid, evt_core, evt_kind, evt_code);
      end
      pop();
      core_active = 4'b0000;
      tick();
   endtask

   task automatic test_hit_vs_timeout();
      core_active = 4'b0001;
      tick();
      n_vec++;
      if (pass_status !== 4'b0000) begin
         n_err++;
         $display("FAIL rerun_clear: got pass=%b expected 0000", pass_status);
      end
      repeat (15) tick();
      store(2'd0, ADDR, 64'h1, 1'b1);
      n_vec++;
      if ({pass_status, fail_status} !== 8'b0001_0110) begin
         n_err++;
         $display("FAIL race_status: got pass=%b fail=%b expected 0001/0110", pass_status, fail_status);
      end
      n_vec++;
      if ({evt_valid, evt_core, evt_kind, evt_code} !== {1'b1, 2'd0, 2'd1, 32'd0}) begin
         n_err++;
         $display("FAIL race_evt: got v=%b core=%0d kind=%0d code=%h expected 1/0/1/0", evt_valid, evt_core, evt_kind, evt_code);
      end
      pop();
      repeat (2) tick();
      n_vec++;
      if (evt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL race_no_timeout: got evt_valid=%b expected 0", evt_valid);
      end
      core_active = 4'b0000;
      tick();
   endtask

   task automatic test_ignored();
      logic [31:0] bad_addr;
      logic [63:0] datas [3];
      logic [31:0] addrs [3];
      logic        ens   [3];
      bad_addr = ADDR + 32'h8;
      datas = '{64'h1, 64'h1, 64'h2};
      addrs = '{ADDR, bad_addr, ADDR};
      ens   = '{1'b0, 1'b1, 1'b1};
      core_active = 4'b1000;
      tick();
      for (int k = 0; k < 3; k++) begin
         store(2'd3, addrs[k], datas[k], ens[k]);
         n_vec++;
         if ({pass_status, fail_status, evt_valid} !== 9'b0001_0110_0) begin
            n_err++;
            $display("FAIL ignored_%0d: got pass=%b fail=%b v=%b expected 0001/0110/0", k, pass_status, fail_status, evt_valid);
         end
      end
      store(2'd3, ADDR, 64'h1, 1'b1);
      n_vec++;
      if ({pass_status, fail_status, evt_valid} !== 9'b1001_0110_1) begin
         n_err++;
         $display("FAIL ignored_still_run: got pass=%b fail=%b v=%b expected 1001/0110/1", pass_status, fail_status, evt_valid);
      end
      pop();
      core_active = 4'b0000;
      tick();
   endtask

   task automatic test_overflow();
      logic [35:0] exp_evt [4];
      exp_evt = '{{2'd0, 2'd1, 32'd0}, {2'd1, 2'd2, 32'd1}, {2'd2, 2'd2, 32'hA}, {2'd3, 2'd1, 32'd0}};
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      core_active = 4'b1111;
      tick();
      store(2'd0, ADDR, 64'h1, 1'b1);
      store(2'd1, ADDR, 64'h3, 1'b1);
      store(2'd2, ADDR, 64'h15, 1'b1);
      store(2'd3, ADDR, 64'h1, 1'b1);
      n_vec++;
      if (overflow !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_early: got overflow=%b expected 0", overflow);
      end
      core_active = 4'b1110;
      tick();
      core_active = 4'b1111;
      tick();
      store(2'd0, ADDR, 64'h7, 1'b1);
      n_vec++;
      if ({overflow, pass_status, fail_status} !== 9'b1_1000_0111) begin
         n_err++;
         $display("FAIL ovf_status: got ovf=%b pass=%b fail=%b expected 1/1000/0111", overflow, pass_status, fail_status);
      end
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if ({evt_valid, evt_core, evt_kind, evt_code} !== {1'b1, exp_evt[k]}) begin
            n_err++;
            $display("FAIL ovf_order_%0d: got v=%b core=%0d kind=%0d code=%h expected 1/%h", k, evt_valid, evt_core, evt_kind, evt_code, exp_evt[k]);
         end
         pop();
      end
      n_vec++;
      if ({evt_valid, overflow} !== 2'b01) begin
         n_err++;
         $display("FAIL ovf_drained: got v=%b ovf=%b expected 0/1", evt_valid, overflow);
      end
      core_active = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid_run();
      core_active = 4'b0111;
      tick();
      store(2'd0, ADDR, 64'h1, 1'b1);
      store(2'd1, ADDR, 64'h1, 1'b1);
      store(2'd2, ADDR, 64'h1, 1'b1);
      n_vec++;
      if (evt_valid !== 1'b1) begin
         n_err++;
         $display("FAIL mid_queued: got evt_valid=%b expected 1", evt_valid);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({evt_valid, overflow, pass_status, fail_status} !== 10'b0) begin
         n_err++;
         $display("FAIL mid_reset: got v=%b ovf=%b pass=%b fail=%b expected all 0", evt_valid, overflow, pass_status, fail_status);
      end
      n_vec++;
      if ({evt_core, evt_kind, evt_code} !== 36'h0) begin
         n_err++;
         $display("FAIL mid_reset_evt: got core=%0d kind=%0d code=%h expected 0", evt_core, evt_kind, evt_code);
      end
      #2;
      rst_n = 1'b1;
      tick();
      store(2'd1, ADDR, 64'h1, 1'b1);
      n_vec++;
      if ({pass_status, fail_status} !== 8'b0010_0000) begin
         n_err++;
         $display("FAIL fresh_status: got pass=%b fail=%b expected 0010/0000", pass_status, fail_status);
      end
      n_vec++;
      if ({evt_valid, evt_core, evt_kind, evt_code} !== {1'b1, 2'd1, 2'd1, 32'd0}) begin
         n_err++;
         $display("FAIL fresh_evt: got v=%b core=%0d kind=%0d code=%h expected 1/1/1/0", evt_valid, evt_core, evt_kind, evt_code);
      end
      pop();
      n_vec++;
      if (evt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fresh_single: got evt_valid=%b expected 0", evt_valid);
      end
      core_active = 4'b0000;
      tick();
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_timeout();
      test_hit_vs_timeout();
      test_ignored();
      test_overflow();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
